// File: rtl/shared_reg_arb_pkg_amisha.sv
// Shared definitions for the shared-register arbiter: FSM state encoding and
// a constant clog2 helper used to size index and counter fields.
package shared_reg_arb_pkg_amisha;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_LOCKED = 2'd2
    } arb_state_t;

    // Bits needed to hold values 0..value-1 (at least 1).
    function automatic int clog2(input int value);
        int bits;
        bits = 1;
        while ((1 << bits) < value) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/shared_reg_arbiter_amisha_rr_pick.sv
// Combinational round-robin picker: returns the first set request found when
// searching upward from i_ptr+1, wrapping around to 0.
module rr_pick_amisha
    import shared_reg_arb_pkg_amisha::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    // Walk the candidates farthest-first so the nearest set request wins last.
    always_comb begin
        int cand;
        // NOTE: every output gets a default before the search; a path that leaves one unassigned would infer a latch.
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        cand     = 0;
        for (int k = N; k >= 1; k--) begin
            cand = (int'(i_ptr) + k) % N;
            if (i_req[cand]) begin
                o_onehot       = '0;
                o_onehot[cand] = 1'b1;
                o_idx          = IDX_W'(cand);
                o_valid        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shared_reg_arbiter_amisha.sv
// Round-robin arbiter sharing one enable-gated data register among NUM_REQ
// requesters. Optional grant locking is compiled in with `define ARB_LOCK_EN.
module shared_reg_arbiter_amisha
    import shared_reg_arb_pkg_amisha::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 8
`ifdef ARB_LOCK_EN
    ,
    parameter int MAX_LOCK = 8
`endif
) (
    input  logic                        clk_amisha,
    input  logic                        reset_amisha,
    input  logic [NUM_REQ-1:0]          req_amisha,
    input  logic [NUM_REQ*DATA_W-1:0]   d_amisha,
`ifdef ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]          lock_amisha,
`endif
    output logic [NUM_REQ-1:0]          gnt_amisha,
    output logic                        en_amisha,
    output logic [DATA_W-1:0]           q_amisha,
    output logic [clog2(NUM_REQ)-1:0]   owner_amisha,
    output logic                        busy_amisha
);

    localparam int IDX_W = clog2(NUM_REQ);
`ifdef ARB_LOCK_EN
    localparam int LOCK_W = clog2(MAX_LOCK + 1);
`endif

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [NUM_REQ-1:0]  w_gnt_nxt;
    logic [IDX_W-1:0]    r_win;
    logic [IDX_W-1:0]    w_win_nxt;
    logic [IDX_W-1:0]    r_ptr;
    logic [IDX_W-1:0]    r_owner;
    logic [DATA_W-1:0]   r_q;
    logic                w_write;
    logic [DATA_W-1:0]   w_d_sel;
    logic [NUM_REQ-1:0]  w_pick_req;
    logic [IDX_W-1:0]    w_pick_ptr;
    logic [NUM_REQ-1:0]  w_pick_onehot;
    logic [IDX_W-1:0]    w_pick_idx;
    logic                w_pick_valid;
`ifdef ARB_LOCK_EN
    logic [LOCK_W-1:0]   r_lock_cnt;
    logic [LOCK_W-1:0]   w_lock_cnt_nxt;
`endif

    // Idle searches all requests from the stored pointer; while granting, the
    // current winner is excluded and the search starts just after it.
    assign w_pick_req = (r_state == ST_IDLE) ? req_amisha : (req_amisha & ~r_gnt);
    assign w_pick_ptr = (r_state == ST_IDLE) ? r_ptr : r_win;
    assign w_d_sel    = d_amisha[r_win*DATA_W +: DATA_W];

    rr_pick_amisha #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req    (w_pick_req),
        .i_ptr    (w_pick_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_valid  (w_pick_valid)
    );

    // Next-state and next-grant decision; a granted cycle always writes.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_win_nxt   = r_win;
        w_write     = (r_state != ST_IDLE);
`ifdef ARB_LOCK_EN
        w_lock_cnt_nxt = r_lock_cnt;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_gnt_nxt   = w_pick_onehot;
                    w_win_nxt   = w_pick_idx;
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
`ifdef ARB_LOCK_EN
                // A requester just forced out of a lock may not re-lock until
                // someone else has written.
                if (r_win != r_ptr) begin
                    w_lock_cnt_nxt = '0;
                end
                if (lock_amisha[r_win] &&
                    !(r_lock_cnt == LOCK_W'(MAX_LOCK) && r_win == r_ptr)) begin
                    w_lock_cnt_nxt = '0;
                    w_state_nxt    = ST_LOCKED;
                end else
`endif
                if (w_pick_valid) begin
                    w_gnt_nxt   = w_pick_onehot;
                    w_win_nxt   = w_pick_idx;
                    w_state_nxt = ST_GRANT;
                end else begin
                    w_gnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end
            end
`ifdef ARB_LOCK_EN
            ST_LOCKED: begin
                if (lock_amisha[r_win] && (int'(r_lock_cnt) + 1 < MAX_LOCK)) begin
                    w_lock_cnt_nxt = r_lock_cnt + LOCK_W'(1);
                end else begin
                    w_lock_cnt_nxt = lock_amisha[r_win] ? LOCK_W'(MAX_LOCK) : '0;
                    if (w_pick_valid) begin
                        w_gnt_nxt   = w_pick_onehot;
                        w_win_nxt   = w_pick_idx;
                        w_state_nxt = ST_GRANT;
                    end else begin
                        w_gnt_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
`endif
            default: begin
                w_gnt_nxt   = '0;
                w_write     = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, grant, pointer and storage registers; reset wins over any write.
    always_ff @(posedge clk_amisha) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset_amisha) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_win   <= '0;
            r_ptr   <= IDX_W'(NUM_REQ - 1);
            r_owner <= '0;
            r_q     <= '0;
`ifdef ARB_LOCK_EN
            r_lock_cnt <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_win   <= w_win_nxt;
`ifdef ARB_LOCK_EN
            r_lock_cnt <= w_lock_cnt_nxt;
`endif
            if (w_write) begin
                r_q     <= w_d_sel;
                r_owner <= r_win;
                r_ptr   <= r_win;
            end
        end
    end

    assign gnt_amisha   = r_gnt;
    assign en_amisha    = |r_gnt;
    assign q_amisha     = r_q;
    assign owner_amisha = r_owner;
    assign busy_amisha  = (r_state != ST_IDLE);

endmodule
